// File: rtl/debounce_pkg.sv
// Shared encodings and counter widths for the key debouncer channels.
package debounce_pkg;

    localparam int unsigned DEB_CNT_W  = 8;
    localparam int unsigned HOLD_CNT_W = 16;

    typedef logic [DEB_CNT_W-1:0]  deb_cnt_t;
    typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_W_PRESS = 2'd1;
    localparam logic [1:0] ST_PRESSED = 2'd2;
    localparam logic [1:0] ST_W_REL   = 2'd3;

endpackage

// File: rtl/debounce_ch.sv
// One key channel: 2-flop synchroniser, qualify/abort FSM, hold and repeat counters.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned DEB_TICKS    = 8,
    parameter int unsigned LONG_TICKS   = 600,
    parameter int unsigned REPEAT_TICKS = 150
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_rel,
    output logic key_long
);

    localparam deb_cnt_t  DEB_LAST = DEB_CNT_W'(DEB_TICKS - 1);
    localparam bit        LONG_EN  = (LONG_TICKS != 0);
    localparam bit        REP_EN   = (REPEAT_TICKS != 0);
    localparam hold_cnt_t LONG_CNT = HOLD_CNT_W'(LONG_TICKS);
    localparam hold_cnt_t LONG_M1  = HOLD_CNT_W'(LONG_EN ? LONG_TICKS - 1 : 0);
    localparam hold_cnt_t REP_CNT  = HOLD_CNT_W'(REPEAT_TICKS);
    localparam hold_cnt_t HOLD_MAX = '1;

    logic [1:0] sync_q;
    logic [1:0] state_q, state_d;
    deb_cnt_t   cnt_q, cnt_d;
    hold_cnt_t  hold_q, hold_d;
    hold_cnt_t  rep_q, rep_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       rel_q, rel_d;
    logic       long_q, long_d;
    logic       p_c;

    assign p_c = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= {2{ACTIVE_LOW}};
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (p_c) state_d = ST_W_PRESS;
            end
            ST_W_PRESS: begin
                if (!p_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                        cnt_d   = '0;
                        hold_d  = '0;
                        rep_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PRESSED: begin
                if (!p_c) begin
                    state_d = ST_W_REL;
                    cnt_d   = '0;
                end else if (en) begin
                    if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
                    // First long pulse on reaching LONG_TICKS, then repeats keep going even once hold saturates
                    if (LONG_EN && hold_q == LONG_M1) begin
                        long_d = 1'b1;
                        rep_d  = '0;
                    end else if (LONG_EN && REP_EN && hold_q >= LONG_CNT) begin
                        if (rep_q + 1'b1 == REP_CNT) begin
                            long_d = 1'b1;
                            rep_d  = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
            end
            ST_W_REL: begin
                if (p_c) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    rep_d   = '0;
                end else if (en) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_IDLE;
                        rel_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        level_d = (state_d == ST_PRESSED) || (state_d == ST_W_REL);
    end

    assign key_level = level_q;
    assign key_press = press_q;
    assign key_rel   = rel_q;
    assign key_long  = long_q;

endmodule

// File: rtl/debouncer_nch.sv
// N-channel front-panel key debouncer: one debounce_ch per key plus an any-key level.
module debouncer_nch
    import debounce_pkg::*;
#(
    parameter int unsigned CH           = 4,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned DEB_TICKS    = 8,
    parameter int unsigned LONG_TICKS   = 600,
    parameter int unsigned REPEAT_TICKS = 150
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [CH-1:0] key_in,
    output logic [CH-1:0] key_level,
    output logic [CH-1:0] key_press,
    output logic [CH-1:0] key_rel,
    output logic [CH-1:0] key_long,
    output logic          any_level
);

    for (genvar g = 0; g < int'(CH); g++) begin : g_ch
        debounce_ch #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .DEB_TICKS   (DEB_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .key_in   (key_in[g]),
            .key_level(key_level[g]),
            .key_press(key_press[g]),
            .key_rel  (key_rel[g]),
            .key_long (key_long[g])
        );
    end

    assign any_level = |key_level;

endmodule

// File: tb/tb_debouncer_nch.sv
// Randomised scoreboard bench for debouncer_nch: two configurations driven by the same keys.
module tb_debouncer_nch;

    localparam int CH    = 4;
    localparam int DEB0  = 8;
    localparam int LONG0 = 24;
    localparam int REP0  = 5;
    localparam int DEB1  = 1;
    localparam int LONG1 = 6;
    localparam int REP1  = 0;

    logic clk = 1'b0;
    logic reset, en;
    logic [CH-1:0] key0, key1;
    logic [CH-1:0] lvl0, pr0, rl0, lg0, lvl1, pr1, rl1, lg1;
    logic any0, any1;

    assign key1 = ~key0;

    always #5 clk = ~clk;

    debouncer_nch #(.CH(CH), .ACTIVE_LOW(1'b1), .DEB_TICKS(DEB0), .LONG_TICKS(LONG0), .REPEAT_TICKS(REP0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .key_in(key0),
        .key_level(lvl0), .key_press(pr0), .key_rel(rl0), .key_long(lg0), .any_level(any0));

    debouncer_nch #(.CH(CH), .ACTIVE_LOW(1'b0), .DEB_TICKS(DEB1), .LONG_TICKS(LONG1), .REPEAT_TICKS(REP1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .key_in(key1),
        .key_level(lvl1), .key_press(pr1), .key_rel(rl1), .key_long(lg1), .any_level(any1));

    typedef struct {int cyc; int inst; int ch; int kind;} ev_t;
    ev_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_mode = 0;

    // Reference model: accepted level plus a count of en ticks the pin has disagreed with it
    bit mlvl [2][CH];
    bit mact [2][CH];
    int mcnt [2][CH];
    int mhold[2][CH];
    int mrep [2][CH];
    logic [CH-1:0] ph1, ph2;

    function automatic int deb_t(int i);  return (i == 0) ? DEB0  : DEB1;  endfunction
    function automatic int long_t(int i); return (i == 0) ? LONG0 : LONG1; endfunction
    function automatic int rep_t(int i);  return (i == 0) ? REP0  : REP1;  endfunction

    function automatic logic [CH-1:0] dut_vec(int i, int k);
        case (k)
            0:       return (i == 0) ? pr0  : pr1;
            1:       return (i == 0) ? rl0  : rl1;
            2:       return (i == 0) ? lg0  : lg1;
            default: return (i == 0) ? lvl0 : lvl1;
        endcase
    endfunction

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(int i, int c, int k);
        ev_t e;
        e.cyc = cyc; e.inst = i; e.ch = c; e.kind = k;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < CH; c++) begin
                mlvl[i][c] = 1'b0; mact[i][c] = 1'b0;
                mcnt[i][c] = 0; mhold[i][c] = 0; mrep[i][c] = 0;
            end
        ph1 = '0;
        ph2 = '0;
    endtask

    task automatic step(int i, int c, bit p, bit e);
        if (p != mlvl[i][c]) begin
            if (!mact[i][c]) begin
                mact[i][c] = 1'b1;
                mcnt[i][c] = 0;
            end else if (e) begin
                mcnt[i][c]++;
                if (mcnt[i][c] == deb_t(i)) begin
                    mlvl[i][c] = p;
                    mact[i][c] = 1'b0;
                    push(i, c, p ? 0 : 1);
                    if (p) begin mhold[i][c] = 0; mrep[i][c] = 0; end
                end
            end
        end else if (mact[i][c]) begin
            mact[i][c] = 1'b0;
            if (p) mrep[i][c] = 0;
        end else if (p && e) begin
            if (long_t(i) != 0 && mhold[i][c] == long_t(i) - 1) begin
                push(i, c, 2);
                mrep[i][c] = 0;
            end else if (long_t(i) != 0 && rep_t(i) != 0 && mhold[i][c] >= long_t(i)) begin
                mrep[i][c]++;
                if (mrep[i][c] == rep_t(i)) begin
                    push(i, c, 2);
                    mrep[i][c] = 0;
                end
            end
            if (mhold[i][c] < 65535) mhold[i][c]++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) model_reset();
            else begin
                for (int i = 0; i < 2; i++)
                    for (int c = 0; c < CH; c++) step(i, c, ph2[c], en);
                ph2 = ph1;
                ph1 = ~key0;
            end
        end
    end

    // Monitor: levels every cycle, pulses matched against the expected-event queue
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    check($sformatf("missed_pulse i%0d ch%0d kind%0d", exp_q[0].inst, exp_q[0].ch, exp_q[0].kind), 0, 1);
                    void'(exp_q.pop_front());
                end
                for (int i = 0; i < 2; i++) begin
                    logic [CH-1:0] lv;
                    int ml;
                    lv = dut_vec(i, 3);
                    ml = 0;
                    for (int c = 0; c < CH; c++) begin
                        check($sformatf("level i%0d ch%0d", i, c), int'(lv[c]), int'(mlvl[i][c]));
                        if (mlvl[i][c]) ml = 1;
                        for (int k = 0; k < 3; k++) begin
                            logic [CH-1:0] v;
                            v = dut_vec(i, k);
                            if (v[c]) begin
                                bit ok;
                                ok = exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].inst == i
                                     && exp_q[0].ch == c && exp_q[0].kind == k;
                                check($sformatf("pulse i%0d ch%0d kind%0d", i, c, k), int'(ok), 1);
                                if (ok) void'(exp_q.pop_front());
                            end
                        end
                    end
                    check($sformatf("any_level i%0d", i), (i == 0) ? int'(any0) : int'(any1), ml);
                end
            end
        end
    end

    // en generator: 0 = every clock, 1 = random 1-in-4, 2 = every 4th clock
    initial begin
        int div;
        div = 0;
        en = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            case (en_mode)
                0:       en = 1'b1;
                1:       en = ($urandom_range(0, 3) == 0);
                default: en = (div == 0);
            endcase
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_lvl0"}, int'(lvl0), 0);
        check({tag, "_pulses0"}, int'(pr0 | rl0 | lg0), 0);
        check({tag, "_any0"}, int'(any0), 0);
        check({tag, "_lvl1"}, int'(lvl1), 0);
        check({tag, "_pulses1"}, int'(pr1 | rl1 | lg1), 0);
        check({tag, "_any1"}, int'(any1), 0);
    endtask

    task automatic random_phase(int n, int flip_div);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, flip_div - 1) == 0) key0[c] = ~key0[c];
        end
    endtask

    initial begin
        int t0, lat0, lat1, found;
        reset = 1'b1;
        key0 = '1;
        idle(2);
        check_all_zero("reset");
        reset = 1'b0;
        idle(3);

        // Press latency in both configurations with en every clock
        en_mode = 0;
        idle(2);
        key0[0] = 1'b0;
        t0 = cyc + 1;
        lat0 = -1;
        lat1 = -1;
        for (int t = 0; t < 40 && lat0 < 0; t++) begin
            @(negedge clk);
            if (pr1[0] && lat1 < 0) lat1 = cyc - t0 + 1;
            if (pr0[0]) lat0 = cyc - t0 + 1;
        end
        check("press_latency_deb8", lat0, 2 + DEB0 + 1);
        check("press_latency_deb1", lat1, 2 + DEB1 + 1);
        idle(20);
        key0[0] = 1'b1;
        idle(20);

        // Short glitch on ch1
        key0[1] = 1'b0; idle(5); key0[1] = 1'b1; idle(20);

        // Release bounce on ch0, then clean release
        key0[0] = 1'b0; idle(20);
        for (int r = 0; r < 3; r++) begin
            key0[0] = 1'b1; idle(3); key0[0] = 1'b0; idle(6);
        end
        key0[0] = 1'b1; idle(20);

        // Long press with repeats on ch2
        key0[2] = 1'b0; idle(60); key0[2] = 1'b1; idle(20);

        // Randomised traffic: bouncy and slow keys, en every clock and sparse
        random_phase(800, 3);
        random_phase(1500, 70);
        en_mode = 1;
        random_phase(800, 4);
        random_phase(2500, 120);
        key0 = '1;
        idle(100);

        // Simultaneous press on ch0 and ch3 with en every 4th clock
        en_mode = 2;
        key0[0] = 1'b0; key0[3] = 1'b0;
        idle(80);
        key0 = '1;
        idle(80);

        // Reset while ch0 is held
        en_mode = 0;
        key0[0] = 1'b0;
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (lvl0[0]) found = 1;
        end
        check("held_before_reset", found, 1);
        idle(10);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (pr0[0]) found = 1;
        end
        check("repress_after_reset", found, 1);
        idle(20);
        key0 = '1;
        idle(40);

        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
